batch_scheduler: RTL and testbench

BATCH_SCHEDULER -- requirements
Module: batch_scheduler

---
 rtl/batch_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_batch_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_scheduler.sv
// Batch scheduler: accepts batches from NUM_REQ requesters in round-robin order and
// tracks them in an in-flight slot table. A batch whose read/write deps collide with an
// in-flight batch waits until that batch retires.
module batch_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int MAX_DEPENDENCIES = 256,
    parameter int MAX_INFLIGHT     = 4,
    localparam int SLOT_W          = $clog2(MAX_INFLIGHT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*MAX_DEPENDENCIES-1:0] req_read_deps,
    input  logic [NUM_REQ*MAX_DEPENDENCIES-1:0] req_write_deps,
    input  logic [NUM_REQ*64-1:0]               req_owner_id,
    output logic                                dispatch_valid,
    input  logic                                dispatch_ready,
    output logic [SLOT_W-1:0]                   dispatch_slot,
    output logic [2:0]                          dispatch_req_id,
    output logic [63:0]                         dispatch_owner_id,
    input  logic                                retire_valid,
    input  logic [SLOT_W-1:0]                   retire_slot,
    output logic [31:0]                         inflight_count,
    output logic [31:0]                         stall_count,
    output logic [31:0]                         dispatched_count,
    output logic                                retire_error
);
    localparam int D = MAX_DEPENDENCIES;

    typedef enum logic {IDLE = 1'b0, DISPATCH = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [MAX_INFLIGHT-1:0] slot_valid_reg, slot_valid_next;
    logic [D-1:0]            slot_rd_reg    [MAX_INFLIGHT];
    logic [D-1:0]            slot_wr_reg    [MAX_INFLIGHT];
    logic [63:0]             slot_owner_reg [MAX_INFLIGHT];
    logic [2:0]              rr_ptr_reg;
    logic [SLOT_W-1:0]       dispatch_slot_reg;
    logic [2:0]              dispatch_req_id_reg;
    logic [31:0]             inflight_count_reg, stall_count_reg, dispatched_count_reg;
    logic                    retire_error_reg;

    logic [NUM_REQ-1:0]      conflict, eligible;
    logic                    free_any;
    logic [SLOT_W-1:0]       free_slot;
    logic [2*NUM_REQ-1:0]    elig_dbl;
    logic [NUM_REQ-1:0]      elig_rot;
    logic                    grant_any, alloc;
    logic [3:0]              grant_ofs, grant_sum;
    logic [2:0]              grant_idx;
    logic [D-1:0]            grant_rd, grant_wr;
    logic [63:0]             grant_owner;

    // Lowest-index free slot, taken from the pre-edge table so a same-cycle retire never frees it.
    always_comb begin
        free_any  = 1'b0;
        free_slot = '0;
        for (int s = MAX_INFLIGHT - 1; s >= 0; s--) begin
            if (!slot_valid_reg[s]) begin
                free_any  = 1'b1;
                free_slot = SLOT_W'(s);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [MAX_INFLIGHT-1:0] hit;
        for (genvar gs = 0; gs < MAX_INFLIGHT; gs++) begin : g_slot
            assign hit[gs] = slot_valid_reg[gs] &
                (|((req_write_deps[gi*D +: D] & slot_rd_reg[gs]) |
                   (req_write_deps[gi*D +: D] & slot_wr_reg[gs]) |
                   (req_read_deps[gi*D +: D]  & slot_wr_reg[gs])));
        end
        assign conflict[gi] = |hit;
        assign eligible[gi] = req_valid[gi] & ~conflict[gi] & free_any;
    end

    // Rotate so rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        elig_dbl  = {eligible, eligible} >> rr_ptr_reg;
        elig_rot  = elig_dbl[NUM_REQ-1:0];
        grant_any = |elig_rot;
        grant_ofs = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) grant_ofs = 4'(k);
        end
        grant_sum = 4'(rr_ptr_reg) + grant_ofs;
        grant_idx = (grant_sum >= 4'(NUM_REQ)) ? 3'(grant_sum - 4'(NUM_REQ)) : 3'(grant_sum);
    end

    always_comb begin
        grant_rd    = '0;
        grant_wr    = '0;
        grant_owner = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == 3'(r)) begin
                grant_rd    = req_read_deps[r*D +: D];
                grant_wr    = req_write_deps[r*D +: D];
                grant_owner = req_owner_id[r*64 +: 64];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        alloc      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any && rst_n) begin
                    alloc      = 1'b1;
                    req_ready  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
                    state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                if (dispatch_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        slot_valid_next = slot_valid_reg;
        if (retire_valid) slot_valid_next[retire_slot] = 1'b0;
        if (alloc)        slot_valid_next[free_slot]   = 1'b1;
    end

    function automatic logic [31:0] popcount(input logic [MAX_INFLIGHT-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_reg       <= '0;
            rr_ptr_reg           <= '0;
            dispatch_slot_reg    <= '0;
            dispatch_req_id_reg  <= '0;
            inflight_count_reg   <= '0;
            stall_count_reg      <= '0;
            dispatched_count_reg <= '0;
            retire_error_reg     <= 1'b0;
            for (int s = 0; s < MAX_INFLIGHT; s++) begin
                slot_rd_reg[s]    <= '0;
                slot_wr_reg[s]    <= '0;
                slot_owner_reg[s] <= '0;
            end
        end else begin
            slot_valid_reg     <= slot_valid_next;
            inflight_count_reg <= popcount(slot_valid_next);
            if (retire_valid && !slot_valid_reg[retire_slot]) retire_error_reg <= 1'b1;
            if (alloc) begin
                slot_rd_reg[free_slot]    <= grant_rd;
                slot_wr_reg[free_slot]    <= grant_wr;
                slot_owner_reg[free_slot] <= grant_owner;
                dispatch_slot_reg         <= free_slot;
                dispatch_req_id_reg       <= grant_idx;
            end
            if (state_reg == IDLE && (|req_valid) && !alloc && stall_count_reg != 32'hFFFF_FFFF)
                stall_count_reg <= stall_count_reg + 32'd1;
            if (dispatch_valid && dispatch_ready) begin
                rr_ptr_reg <= (dispatch_req_id_reg == 3'(NUM_REQ - 1)) ? 3'd0
                                                                        : dispatch_req_id_reg + 3'd1;
                dispatched_count_reg <= dispatched_count_reg + 32'd1;
            end
        end
    end

    // The owner is read back from the slot; nothing can reallocate that slot while dispatching.
    assign dispatch_valid    = (state_reg == DISPATCH);
    assign dispatch_slot     = dispatch_slot_reg;
    assign dispatch_req_id   = dispatch_req_id_reg;
    assign dispatch_owner_id = slot_owner_reg[dispatch_slot_reg];
    assign inflight_count    = inflight_count_reg;
    assign stall_count       = stall_count_reg;
    assign dispatched_count  = dispatched_count_reg;
    assign retire_error      = retire_error_reg;

endmodule

// File: tb/tb_batch_scheduler.sv
// Bench for batch_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the slot table and arbiter.
module tb_batch_scheduler;
    localparam int NR = 4;
    localparam int ND = 256;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*ND-1:0] req_read_deps, req_write_deps;
    logic [NR*64-1:0] req_owner_id;
    logic            dispatch_valid, dispatch_ready;
    logic [1:0]      dispatch_slot;
    logic [2:0]      dispatch_req_id;
    logic [63:0]     dispatch_owner_id;
    logic            retire_valid;
    logic [1:0]      retire_slot;
    logic [31:0]     inflight_count, stall_count, dispatched_count;
    logic            retire_error;

    logic [ND-1:0]   rd_in [NR];
    logic [ND-1:0]   wr_in [NR];
    logic [63:0]     own_in [NR];

    always #5 clk = ~clk;

    always_comb begin
        req_read_deps  = '0;
        req_write_deps = '0;
        req_owner_id   = '0;
        for (int r = 0; r < NR; r++) begin
            req_read_deps[r*ND +: ND]  = rd_in[r];
            req_write_deps[r*ND +: ND] = wr_in[r];
            req_owner_id[r*64 +: 64]   = own_in[r];
        end
    end

    batch_scheduler #(.NUM_REQ(NR), .MAX_DEPENDENCIES(ND), .MAX_INFLIGHT(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read_deps(req_read_deps), .req_write_deps(req_write_deps),
        .req_owner_id(req_owner_id),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_slot(dispatch_slot), .dispatch_req_id(dispatch_req_id),
        .dispatch_owner_id(dispatch_owner_id),
        .retire_valid(retire_valid), .retire_slot(retire_slot),
        .inflight_count(inflight_count), .stall_count(stall_count),
        .dispatched_count(dispatched_count), .retire_error(retire_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model
    bit          m_valid [NS];
    logic [ND-1:0] m_rd [NS];
    logic [ND-1:0] m_wr [NS];
    bit          m_disp;
    int          m_dslot, m_dreq, m_rr;
    logic [63:0] m_downer;
    logic [31:0] m_stall, m_dcount;
    int          m_inflight;
    bit          m_err;
    bit          e_gnt;
    int          e_gidx, e_fslot;
    logic [NR-1:0] last_ready;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 0; m_rd[s] = '0; m_wr[s] = '0;
        end
        m_disp = 0; m_dslot = 0; m_dreq = 0; m_rr = 0; m_downer = '0;
        m_stall = '0; m_dcount = '0; m_inflight = 0; m_err = 0;
    endtask

    function automatic bit conflicts(int r);
        for (int s = 0; s < NS; s++)
            if (m_valid[s] && (((wr_in[r] & m_rd[s]) | (wr_in[r] & m_wr[s]) | (rd_in[r] & m_wr[s])) != '0))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_comb();
        e_gnt = 0; e_gidx = 0; e_fslot = -1;
        for (int s = 0; s < NS; s++) if (!m_valid[s]) begin e_fslot = s; break; end
        if (!m_disp && e_fslot >= 0) begin
            for (int k = 0; k < NR; k++) begin
                int r;
                r = (m_rr + k) % NR;
                if (req_valid[r] && !conflicts(r)) begin e_gnt = 1; e_gidx = r; break; end
            end
        end
    endtask

    task automatic model_edge();
        bit nv [NS];
        nv = m_valid;
        if (!m_disp && req_valid != 0 && !e_gnt && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (retire_valid) begin
            if (m_valid[retire_slot]) nv[retire_slot] = 0;
            else m_err = 1;
        end
        if (e_gnt) begin
            nv[e_fslot] = 1;
            m_rd[e_fslot] = rd_in[e_gidx];
            m_wr[e_fslot] = wr_in[e_gidx];
            m_disp = 1; m_dslot = e_fslot; m_dreq = e_gidx; m_downer = own_in[e_gidx];
            $display("t=%0t grant req=%0d slot=%0d owner=%0h", $time, e_gidx, e_fslot, m_downer);
        end else if (m_disp && dispatch_ready) begin
            m_disp = 0;
            m_rr = (m_dreq + 1) % NR;
            m_dcount++;
        end
        m_valid = nv;
        m_inflight = 0;
        for (int s = 0; s < NS; s++) if (m_valid[s]) m_inflight++;
    endtask

    // One clock cycle: called just after a negedge with inputs already driven.
    task automatic step();
        logic [NR-1:0] exp_ready;
        #1;
        model_comb();
        exp_ready = e_gnt ? (4'b0001 << e_gidx) : 4'b0000;
        last_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("dispatch_valid", dispatch_valid, m_disp);
        if (m_disp) begin
            check("dispatch_slot", dispatch_slot, m_dslot);
            check("dispatch_req_id", dispatch_req_id, m_dreq);
            check("dispatch_owner_id", dispatch_owner_id, m_downer);
        end
        check("inflight_count", inflight_count, m_inflight);
        check("stall_count", stall_count, m_stall);
        check("dispatched_count", dispatched_count, m_dcount);
        check("retire_error", retire_error, m_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_dispatch_valid", dispatch_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_dispatch_slot", dispatch_slot, 0);
        check("rst_dispatch_req_id", dispatch_req_id, 0);
        check("rst_dispatch_owner", dispatch_owner_id, 0);
        check("rst_inflight", inflight_count, 0);
        check("rst_stall", stall_count, 0);
        check("rst_dispatched", dispatched_count, 0);
        check("rst_retire_error", retire_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_idle();
        req_valid = '0; retire_valid = 0; retire_slot = '0; dispatch_ready = 1;
        for (int r = 0; r < NR; r++) begin
            rd_in[r] = '0; wr_in[r] = '0; own_in[r] = 64'h1000 + 64'(r);
        end
    endtask

    task automatic disjoint_deps();
        for (int r = 0; r < NR; r++) begin
            rd_in[r] = 256'(1) << (2 * r);
            wr_in[r] = 256'(1) << (2 * r + 1);
        end
    endtask

    function automatic logic [ND-1:0] rand_dep();
        int pos [8] = '{0, 1, 2, 3, 128, 253, 254, 255};
        logic [ND-1:0] d = '0;
        int n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) d |= 256'(1) << pos[$urandom_range(0, 7)];
        return d;
    endfunction

    initial begin
        rst_n = 1'b0;
        set_idle();
        req_valid = 4'b1111;
        disjoint_deps();
        @(negedge clk);
        do_reset();

        // First grant: accept at cycle 0, dispatch at cycle 1 in slot 0
        set_idle();
        req_valid = 4'b0001; rd_in[0] = 256'h1; wr_in[0] = 256'h2; own_in[0] = 64'hA0;
        step();
        check("r46_ready", last_ready, 4'b0001);
        check("r46_dv", dispatch_valid, 1);
        check("r46_slot", dispatch_slot, 0);
        check("r46_req", dispatch_req_id, 0);
        check("r46_inflight", inflight_count, 1);
        req_valid = '0;
        step();

        // Read-after-write conflict blocks until slot 0 retires
        req_valid = 4'b0010; rd_in[1] = 256'h2; wr_in[1] = 256'h10;
        repeat (3) step();
        check("r47_stall", stall_count, 3);
        retire_valid = 1; retire_slot = 2'd0;
        step();
        check("r47_ready_retire", last_ready, 0);
        retire_valid = 0;
        step();
        check("r47_ready", last_ready, 4'b0010);
        check("r47_slot", dispatch_slot, 0);
        check("r47_req", dispatch_req_id, 1);
        check("r47_stall_after", stall_count, 4);
        req_valid = '0;
        step();
        retire_valid = 1; retire_slot = 2'd0;
        step();
        retire_valid = 0;

        // Round robin with immediate retire
        do_reset();
        set_idle();
        disjoint_deps();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("r48_order", dispatch_req_id, i % 4);
            retire_valid = 1; retire_slot = 2'(m_dslot);
            step();
            retire_valid = 0;
        end
        check("r48_count", dispatched_count, 5);

        // Full table, then retire of slot 2 frees room next cycle
        do_reset();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            rd_in[0] = 256'(1) << (10 + 2 * i);
            wr_in[0] = 256'(1) << (11 + 2 * i);
            step();
            check("r49_fill_slot", dispatch_slot, i);
            req_valid = '0;
            step();
        end
        check("r49_full", inflight_count, 4);
        req_valid = 4'b0010; rd_in[1] = 256'(1) << 40; wr_in[1] = 256'(1) << 41;
        repeat (3) step();
        check("r49_stall", stall_count, 3);
        check("r49_ready_full", last_ready, 0);
        retire_valid = 1; retire_slot = 2'd2;
        step();
        check("r49_ready_retire", last_ready, 0);
        retire_valid = 0;
        step();
        check("r49_ready", last_ready, 4'b0010);
        check("r49_slot", dispatch_slot, 2);
        req_valid = '0;
        step();

        // Backpressure in DISPATCH, bad retire, then reset mid-dispatch
        do_reset();
        set_idle();
        disjoint_deps();
        own_in[2] = 64'hCAFE_F00D_1234_5678;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0100; dispatch_ready = 0;
        step();
        check("r50_grant_slot", dispatch_slot, 1);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            retire_valid = (i == 1); retire_slot = 2'd3;
            step();
            check("r50_ready", last_ready, 0);
            check("r50_slot", dispatch_slot, 1);
            check("r50_req", dispatch_req_id, 2);
            check("r50_owner", dispatch_owner_id, 64'hCAFE_F00D_1234_5678);
            check("r50_stall", stall_count, 0);
            if (i >= 1) check("r50_retire_error", retire_error, 1);
        end
        retire_valid = 0;
        do_reset();
        dispatch_ready = 1;
        step();
        check("r51_rr", dispatch_req_id, 0);

        // Random traffic
        do_reset();
        set_idle();
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int r = 0; r < NR; r++) begin
                rd_in[r] = rand_dep();
                wr_in[r] = rand_dep();
                own_in[r] = {$urandom, $urandom};
            end
            dispatch_ready = ($urandom_range(0, 3) != 0);
            retire_valid = ($urandom_range(0, 2) == 0);
            retire_slot = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
